voice_scheduler: RTL and testbench

Time-multiplexes the shared sample-increment datapath across NUM_VOICES polyphonic voices. On each rising edge of sample_clk it visits every active voice once, in order: it selects the voice, pulses a step request and waits for the datapath to finish. It also allocates voices on note-on (with round-robin stealing when all voices are busy) and releases them on note-off or end-of-sample. It sits between the keyboard/note front end and the per-voice increment/address datapath and mixer.

---
 rtl/synth_pkg.sv | 16 +
 rtl/voice_alloc.sv | 23 ++
 rtl/voice_scheduler.sv | 168 ++++++++++++++++
 tb/tb_voice_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and default sizing for the voice scheduler and its allocator.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        SCAN,
        ISSUE,
        WAIT_DONE,
        FRAME_DONE
    } sched_state_t;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_NOTE_W     = 7;

endpackage

// File: rtl/voice_alloc.sv
// First-free priority encoder: lowest-index inactive voice, plus a flag saying one exists.
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int VID_W      = 2
) (
    input  logic [NUM_VOICES-1:0] active,
    output logic [VID_W-1:0]      free_idx,
    output logic                  any_free
);

    // Scanning downward lets the lowest free index be the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_idx = VID_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Shares one voice-step datapath across all voices once per sample, and handles
// note-on allocation (with round-robin stealing) and note-off / end-of-sample release.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VID_W      = $clog2(NUM_VOICES),
    parameter int NOTE_W     = DEF_NOTE_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  sample_clk,
    input  logic                  note_on,
    input  logic                  note_off,
    input  logic [NOTE_W-1:0]     note_num,
    input  logic                  step_done,
    input  logic                  end_of_sample,
    output logic [VID_W-1:0]      voice_sel,
    output logic                  step_start,
    output logic                  load_voice,
    output logic [NOTE_W-1:0]     load_note,
    output logic [NUM_VOICES-1:0] active,
    output logic                  frame_done,
    output logic                  note_drop,
    output logic                  frame_overrun
);

    localparam logic [VID_W-1:0] LAST_VOICE = VID_W'(NUM_VOICES - 1);

    sched_state_t      state;
    logic              sclk_q;
    logic              sclk_edge;
    logic              note_pend;
    logic [NOTE_W-1:0] pend_note;
    logic              frame_pend;
    logic [VID_W-1:0]  idx;
    logic [VID_W-1:0]  steal_ptr;
    logic [NOTE_W-1:0] notes [NUM_VOICES];
    logic [VID_W-1:0]  free_idx;
    logic              any_free;

    assign sclk_edge = sample_clk & ~sclk_q;

    voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .VID_W      (VID_W)
    ) u_alloc (
        .active   (active),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            sclk_q        <= 1'b1;
            note_pend     <= 1'b0;
            pend_note     <= '0;
            frame_pend    <= 1'b0;
            idx           <= '0;
            steal_ptr     <= '0;
            voice_sel     <= '0;
            step_start    <= 1'b0;
            load_voice    <= 1'b0;
            load_note     <= '0;
            active        <= '0;
            frame_done    <= 1'b0;
            note_drop     <= 1'b0;
            frame_overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= '0;
            end
        end else begin
            sclk_q        <= sample_clk;
            step_start    <= 1'b0;
            load_voice    <= 1'b0;
            frame_done    <= 1'b0;
            note_drop     <= note_on & note_pend;
            frame_overrun <= 1'b0;

            if (note_on) begin
                note_pend <= 1'b1;
                pend_note <= note_num;
            end

            // A sample edge is only accepted while no frame is queued or running.
            if (sclk_edge) begin
                if (frame_pend || !(state == IDLE || state == ALLOC)) begin
                    frame_overrun <= 1'b1;
                end else begin
                    frame_pend <= 1'b1;
                end
            end

            for (int i = 0; i < NUM_VOICES; i++) begin
                if (note_off && notes[i] == note_num) begin
                    active[i] <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (note_pend) begin
                        state      <= ALLOC;
                        note_pend  <= note_on;
                        load_voice <= 1'b1;
                        load_note  <= pend_note;
                        if (any_free) begin
                            voice_sel <= free_idx;
                        end else begin
                            voice_sel <= steal_ptr;
                            steal_ptr <= steal_ptr + VID_W'(1);
                        end
                    end else if (frame_pend) begin
                        frame_pend <= 1'b0;
                        idx        <= '0;
                        state      <= SCAN;
                    end
                end
                ALLOC: begin
                    // Placed after the note-off loop so a fresh allocation wins its own bit.
                    active[voice_sel] <= 1'b1;
                    notes[voice_sel]  <= load_note;
                    voice_sel         <= '0;
                    load_note         <= '0;
                    state             <= IDLE;
                end
                SCAN: begin
                    if (active[idx]) begin
                        state      <= ISSUE;
                        step_start <= 1'b1;
                        voice_sel  <= idx;
                    end else if (idx == LAST_VOICE) begin
                        state      <= FRAME_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + VID_W'(1);
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (step_done) begin
                        if (end_of_sample) begin
                            active[idx] <= 1'b0;
                        end
                        voice_sel <= '0;
                        if (idx == LAST_VOICE) begin
                            state      <= FRAME_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx + VID_W'(1);
                            state <= SCAN;
                        end
                    end
                end
                FRAME_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench: a table of note events plus hand-built frames; every DUT output
// event is matched against a scoreboard of expected (kind, cycle, voice, note) entries.
module tb_voice_scheduler;

    localparam int NV = 4;
    localparam int VW = 2;
    localparam int NW = 7;

    localparam int K_LOAD = 0;
    localparam int K_STEP = 1;
    localparam int K_FD   = 2;
    localparam int K_DROP = 3;
    localparam int K_OVR  = 4;

    typedef struct {
        int kind;
        int cyc;
        int voice;
        int note;
    } ev_t;

    typedef struct {
        bit           is_on;
        int           note;
        int           exp_voice;
        logic [NV-1:0] exp_active;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          sample_clk;
    logic          note_on;
    logic          note_off;
    logic [NW-1:0] note_num;
    logic          step_done;
    logic          end_of_sample;
    logic [VW-1:0] voice_sel;
    logic          step_start;
    logic          load_voice;
    logic [NW-1:0] load_note;
    logic [NV-1:0] active;
    logic          frame_done;
    logic          note_drop;
    logic          frame_overrun;

    ev_t   exp_q[$];
    vec_t  vecs[9];
    string kname[5] = '{"load", "step", "frame_done", "note_drop", "frame_overrun"};
    int    errors = 0;
    int    checks = 0;
    int    cycle_no = 0;
    bit    dp_arm = 0;
    int    dp_voice = 0;
    logic [NV-1:0] eos_mask = '0;

    voice_scheduler #(.NUM_VOICES(NV), .VID_W(VW), .NOTE_W(NW)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .sample_clk    (sample_clk),
        .note_on       (note_on),
        .note_off      (note_off),
        .note_num      (note_num),
        .step_done     (step_done),
        .end_of_sample (end_of_sample),
        .voice_sel     (voice_sel),
        .step_start    (step_start),
        .load_voice    (load_voice),
        .load_note     (load_note),
        .active        (active),
        .frame_done    (frame_done),
        .note_drop     (note_drop),
        .frame_overrun (frame_overrun)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push(int kind, int cyc, int voice, int note);
        ev_t e;
        e.kind = kind; e.cyc = cyc; e.voice = voice; e.note = note;
        exp_q.push_back(e);
    endtask

    // Expected step/frame_done timing for a frame whose edge is sampled in cycle c0.
    task automatic push_frame(int c0, logic [NV-1:0] mask);
        int t = c0 + 2;
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) begin
                push(K_STEP, t + 1, v, 0);
                t += 3;
            end else begin
                t += 1;
            end
        end
        push(K_FD, t, 0, 0);
    endtask

    task automatic observe(int kind, int v, int n);
        int idx = -1;
        checks++;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: got event at cycle %0d voice %0d note %0d, required none",
                     kname[kind], cycle_no, v, n);
        end else begin
            if (exp_q[idx].cyc != cycle_no || exp_q[idx].voice != v || exp_q[idx].note != n) begin
                errors++;
                $display("FAIL %s: got cycle %0d voice %0d note %0d, required cycle %0d voice %0d note %0d",
                         kname[kind], cycle_no, v, n, exp_q[idx].cyc, exp_q[idx].voice, exp_q[idx].note);
            end else begin
                $display("ok %s cycle %0d voice %0d note %0d", kname[kind], cycle_no, v, n);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("ok %s = %0d", name, got);
        end
    endtask

    // One clock: clears pulses, models the datapath (step_done one cycle after
    // step_start) and feeds every observed output event to the scoreboard.
    task automatic cyc();
        @(posedge Clk);
        #1;
        cycle_no++;
        note_on = 1'b0;
        note_off = 1'b0;
        step_done = 1'b0;
        end_of_sample = 1'b0;
        if (dp_arm) begin
            step_done = 1'b1;
            end_of_sample = eos_mask[dp_voice];
            dp_arm = 0;
        end
        if (step_start === 1'b1) begin
            dp_arm = 1;
            dp_voice = int'(voice_sel);
        end
        if (load_voice === 1'b1)    observe(K_LOAD, int'(voice_sel), int'(load_note));
        if (step_start === 1'b1)    observe(K_STEP, int'(voice_sel), 0);
        if (frame_done === 1'b1)    observe(K_FD, 0, 0);
        if (note_drop === 1'b1)     observe(K_DROP, 0, 0);
        if (frame_overrun === 1'b1) observe(K_OVR, 0, 0);
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) cyc();
        chk({name, "_pending"}, exp_q.size(), 0);
        repeat (3) cyc();
    endtask

    task automatic apply_vec(int i);
        if (vecs[i].is_on) begin
            push(K_LOAD, cycle_no + 2, vecs[i].exp_voice, vecs[i].note);
            note_on = 1'b1;
        end else begin
            note_off = 1'b1;
        end
        note_num = NW'(vecs[i].note);
        repeat (5) cyc();
        chk($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].exp_active));
    endtask

    // Plain frame; optionally pulse note_off(off_note) in cycle c0+off_rel.
    task automatic run_frame(string name, logic [NV-1:0] mask, int off_rel, int off_note);
        int c0;
        sample_clk = 1'b0;
        cyc();
        c0 = cycle_no;
        sample_clk = 1'b1;
        push_frame(c0, mask);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            cyc();
            if (cycle_no - c0 == off_rel) begin
                note_off = 1'b1;
                note_num = NW'(off_note);
            end
        end
        drain(name);
    endtask

    initial begin
        int c0;
        vecs[0] = '{1'b1, 60, 0, 4'b0001};
        vecs[1] = '{1'b1, 62, 1, 4'b0011};
        vecs[2] = '{1'b1, 64, 2, 4'b0111};
        vecs[3] = '{1'b1, 66, 1, 4'b0011};
        vecs[4] = '{1'b1, 68, 2, 4'b0111};
        vecs[5] = '{1'b1, 69, 3, 4'b1111};
        vecs[6] = '{1'b1, 70, 0, 4'b1111};
        vecs[7] = '{1'b1, 70, 1, 4'b1111};
        vecs[8] = '{1'b0, 70, -1, 4'b1100};

        Reset = 1'b1; sample_clk = 1'b1; note_on = 1'b0; note_off = 1'b0;
        note_num = '0; step_done = 1'b0; end_of_sample = 1'b0;

        repeat (3) cyc();
        chk("reset_active", int'(active), 0);
        Reset = 1'b0;
        repeat (10) cyc();
        chk("idle_outputs", int'({voice_sel, step_start, load_voice, load_note, active,
                                  frame_done, note_drop, frame_overrun}), 0);

        run_frame("empty_frame", 4'b0000, -1, 0);

        for (int i = 0; i < 3; i++) apply_vec(i);
        drain("alloc3");

        run_frame("frame_3voices", 4'b0111, -1, 0);
        chk("active_after_frame3", int'(active), 4'b0111);

        eos_mask = 4'b0100;
        run_frame("frame_off_eos", 4'b0111, 7, 62);
        eos_mask = 4'b0000;
        chk("active_after_release", int'(active), 4'b0001);

        run_frame("frame_voice0", 4'b0001, -1, 0);

        for (int i = 3; i < 9; i++) apply_vec(i);
        drain("steal");

        // Second sample edge and two note_ons arrive while the frame is running.
        sample_clk = 1'b0;
        cyc();
        c0 = cycle_no;
        sample_clk = 1'b1;
        push_frame(c0, 4'b1100);
        push(K_OVR, c0 + 6, 0, 0);
        push(K_DROP, c0 + 9, 0, 0);
        push(K_LOAD, c0 + 12, 0, 81);
        for (int k = 0; k < 20; k++) begin
            cyc();
            case (cycle_no - c0)
                3: sample_clk = 1'b0;
                5: sample_clk = 1'b1;
                6: begin note_on = 1'b1; note_num = NW'(80); end
                8: begin note_on = 1'b1; note_num = NW'(81); end
                default: ;
            endcase
        end
        drain("overrun_drop");
        chk("active_after_drop", int'(active), 4'b1101);

        // Reset lands mid-frame with a note queued: nothing may follow it.
        sample_clk = 1'b0;
        cyc();
        sample_clk = 1'b1;
        cyc();
        note_on = 1'b1;
        note_num = NW'(90);
        cyc();
        Reset = 1'b1;
        cyc();
        dp_arm = 0;
        Reset = 1'b0;
        chk("midframe_reset_active", int'(active), 0);
        repeat (12) cyc();
        chk("midframe_reset_quiet", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
